// File: rtl/booth_multiplier_seq.sv
// Sequential signed radix-2 Booth multiplier with its (n+1)-bit adder/subtractor.
// Latency: start accepted at edge k -> busy k+1..k+n, done pulse and product in cycle k+n+1.
// Backpressure: start is only honoured in IDLE/DONE; requests during CALC are dropped, not queued.

// (W)-bit two's-complement adder/subtractor: out_s = in_a + in_b, or in_a - in_b when in_add_n=1.
// Latency: purely combinational.
// Backpressure: none; it has no flow control.
module booth_addsub #(
    parameter int W = 5
) (
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_add_n,
    output logic [W-1:0] out_s,
    output logic         out_cout,
    output logic         out_ovf
);

    logic [W-1:0] w_b_eff;
    logic [W:0]   w_sum;

    // Subtraction is a + ~b + 1; the carry-in is the add_n select itself.
    assign w_b_eff  = in_b ^ {W{in_add_n}};
    assign w_sum    = {1'b0, in_a} + {1'b0, w_b_eff} + {{W{1'b0}}, in_add_n};
    assign out_s    = w_sum[W-1:0];
    assign out_cout = w_sum[W];
    // Signed overflow: both effective operands share a sign that the result lost.
    assign out_ovf  = (in_a[W-1] == w_b_eff[W-1]) && (out_s[W-1] != in_a[W-1]);

endmodule

// Booth multiplier top: one add/sub/pass decision and one arithmetic shift per CALC cycle.
// Latency: n CALC cycles then one DONE cycle; back-to-back throughput one product per n+1 cycles.
// Backpressure: none downstream; out_p holds until the final CALC edge of the next operation.
module booth_multiplier_seq #(
    parameter int n = 4
) (
    input  logic           in_clk,
    input  logic           in_rst,
    input  logic           in_start,
    input  logic [n-1:0]   in_x,
    input  logic [n-1:0]   in_y,
    output logic [2*n-1:0] out_p,
    output logic           out_busy,
    output logic           out_done
);

    localparam int CW = $clog2(n + 1);
    localparam logic [CW-1:0] COUNT_INIT = CW'(n);
    localparam logic [CW-1:0] COUNT_LAST = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    // A carries one bit more than the operands so that subtracting M = -2^(n-1)
    // (i.e. adding +2^(n-1)) never wraps.
    logic [n:0]       r_a;
    logic [n-1:0]     r_q;
    logic             r_q1;
    logic [n-1:0]     r_m;
    logic [CW-1:0]    r_count;
    logic [2*n-1:0]   r_p;
    logic             r_busy;
    logic             r_done;

    logic [n:0]       w_m_ext;
    logic [n:0]       w_sum;
    logic             w_cout;
    logic             w_ovf;
    logic             w_unused;
    logic             w_do_op;
    logic [n:0]       w_a_next;
    logic [n:0]       w_a_sh;
    logic [n-1:0]     w_q_sh;
    logic             w_accept;

    // M is sign-extended into the extra A bit at the adder input.
    assign w_m_ext = {r_m[n-1], r_m};

    // Pair 10 subtracts, 01 adds; Q[0] alone therefore selects the operation.
    booth_addsub #(
        .W (n + 1)
    ) u_addsub (
        .in_a     (r_a),
        .in_b     (w_m_ext),
        .in_add_n (r_q[0]),
        .out_s    (w_sum),
        .out_cout (w_cout),
        .out_ovf  (w_ovf)
    );

    // The widened A makes carry and overflow meaningless here; they are intentionally dropped.
    assign w_unused = &{1'b0, w_cout, w_ovf};

    // Pairs 00 and 11 pass A through unchanged.
    assign w_do_op  = r_q[0] ^ r_q1;
    assign w_a_next = w_do_op ? w_sum : r_a;

    // Arithmetic right shift of {A', Q, q_1}: the sign of A' is replicated,
    // the LSB of A' moves into Q, and Q[0] drops into q_1 (handled in the FSM).
    assign w_a_sh = {w_a_next[n], w_a_next[n:1]};
    assign w_q_sh = {w_a_next[0], r_q[n-1:1]};

    // A new operation may only be accepted while not calculating.
    assign w_accept = in_start && (r_state != S_CALC);

    // Control FSM with datapath registers and registered status outputs.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_q     <= '0;
            r_q1    <= 1'b0;
            r_m     <= '0;
            r_count <= '0;
            r_p     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_a     <= '0;
                        r_q     <= in_y;
                        r_q1    <= 1'b0;
                        r_m     <= in_x;
                        r_count <= COUNT_INIT;
                        r_busy  <= 1'b1;
                        r_state <= S_CALC;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    r_a     <= w_a_sh;
                    r_q     <= w_q_sh;
                    r_q1    <= r_q[0];
                    r_count <= r_count - COUNT_LAST;
                    if (r_count == COUNT_LAST) begin
                        // Bit n of A is only a guard; the product is the low 2n bits.
                        r_p     <= {w_a_sh[n-1:0], w_q_sh};
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign out_p    = r_p;
    assign out_busy = r_busy;
    assign out_done = r_done;

endmodule
